// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the systolic-array tile controllers.
package sa_pkg;

  typedef enum logic [2:0] {IDLE, LOAD_W, FEED, DRAIN, DONE} sa_state_t;

  function automatic int sa_feed_len(input int n, input int lat);
    return (2 * n - 1) * lat;
  endfunction

endpackage

// File: rtl/sa_row_enable_gen.sv
// Skewed per-row multiply-enable decode: row r is active for N*PE_LAT cycles starting at r*PE_LAT.
module sa_row_enable_gen
  import sa_pkg::*;
#(
  parameter int MATRIX_SIZE = 2,
  parameter int PE_LAT      = 4,
  parameter int CNT_W       = $clog2(sa_feed_len(MATRIX_SIZE, PE_LAT) + 1)
) (
  input  logic [CNT_W-1:0]       cnt,
  input  logic                   in_feed,
  output logic [MATRIX_SIZE-1:0] enable_mult
);

  always_comb begin
    enable_mult = '0;
    for (int unsigned r = 0; r < MATRIX_SIZE; r++) begin
      enable_mult[r] = in_feed
                    && (cnt >= CNT_W'(r * PE_LAT))
                    && (cnt <  CNT_W'((r + MATRIX_SIZE) * PE_LAT));
    end
  end

endmodule

// File: rtl/sa_tile_sequencer.sv
// One-pass tile sequencer: weight load, skewed multiply feed, result drain, done pulse.
module sa_tile_sequencer
  import sa_pkg::*;
#(
  parameter int MATRIX_SIZE = 2,
  parameter int PE_LAT      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          start,
  output logic [MATRIX_SIZE-1:0]        load_weight,
  output logic [$clog2(MATRIX_SIZE):0]  w_row_addr,
  output logic                          acc_clear,
  output logic [MATRIX_SIZE-1:0]        enable_mult,
  output logic                          out_valid,
  output logic [$clog2(MATRIX_SIZE):0]  out_row,
  output logic                          busy,
  output logic                          done
);

  localparam int FEED_LEN = sa_feed_len(MATRIX_SIZE, PE_LAT);
  localparam int CNT_W    = $clog2(FEED_LEN + 1);
  localparam int AW       = $clog2(MATRIX_SIZE) + 1;

  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(MATRIX_SIZE - 1);
  localparam logic [CNT_W-1:0] FEED_LAST = CNT_W'(FEED_LEN - 1);

  sa_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;

  // cnt is held at zero in IDLE so it can never wrap while waiting for start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (enable) begin
      state <= state_nxt;
      if (state_nxt != state || state == IDLE) cnt <= '0;
      else                                     cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt   = state;
    load_weight = '0;
    w_row_addr  = '0;
    acc_clear   = 1'b0;
    out_valid   = 1'b0;
    out_row     = '0;
    busy        = (state != IDLE);
    done        = 1'b0;
    unique case (state)
      IDLE:   if (start) state_nxt = LOAD_W;
      LOAD_W: begin
        load_weight = MATRIX_SIZE'(1) << cnt;
        w_row_addr  = AW'(cnt);
        acc_clear   = 1'b1;
        if (cnt == ROW_LAST) state_nxt = FEED;
      end
      FEED:   if (cnt == FEED_LAST) state_nxt = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        out_row   = AW'(cnt);
        if (cnt == ROW_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  sa_row_enable_gen #(
    .MATRIX_SIZE (MATRIX_SIZE),
    .PE_LAT      (PE_LAT),
    .CNT_W       (CNT_W)
  ) u_row_enable (
    .cnt         (cnt),
    .in_feed     (state == FEED),
    .enable_mult (enable_mult)
  );

endmodule
